uvmt_cv32e40s_obi_mem_arbiter: RTL and testbench

Shares one single-port, in-order OBI memory model between the cv32e40s instruction (port A) and data (port B) OBI interfaces in the formal and simulation benches. Arbitrates requests round-robin, holds a pending choice stable until the memory grants it, and tracks up to MAX_OUTSTANDING issued transactions in an order FIFO so each response returns to its originating port. Sits between the core's OBI interfaces and the memory model.

---
 rtl/uvmt_cv32e40s_obi_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_uvmt_cv32e40s_obi_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uvmt_cv32e40s_obi_mem_arbiter.sv
// Shares one single-port, in-order OBI memory model between the cv32e40s
// instruction port (A) and data port (B). Round-robin arbitration, a held
// choice stays stable until granted, and an order FIFO of port ids routes
// every in-order response back to the port that issued it.
module uvmt_cv32e40s_obi_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    a_req_i,
    output logic                    a_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   a_addr_i,
    input  logic                    a_we_i,
    input  logic [DATA_WIDTH/8-1:0] a_be_i,
    input  logic [DATA_WIDTH-1:0]   a_wdata_i,
    output logic                    a_rvalid_o,
    output logic [DATA_WIDTH-1:0]   a_rdata_o,
    output logic                    a_err_o,

    input  logic                    b_req_i,
    output logic                    b_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   b_addr_i,
    input  logic                    b_we_i,
    input  logic [DATA_WIDTH/8-1:0] b_be_i,
    input  logic [DATA_WIDTH-1:0]   b_wdata_i,
    output logic                    b_rvalid_o,
    output logic [DATA_WIDTH-1:0]   b_rdata_o,
    output logic                    b_err_o,

    output logic                    m_req_o,
    output logic [ADDR_WIDTH-1:0]   m_addr_o,
    output logic                    m_we_o,
    output logic [DATA_WIDTH/8-1:0] m_be_o,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    input  logic                    m_gnt_i,
    input  logic                    m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic                    m_err_i,

    output logic                    unexpected_rsp_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        ARB,
        HOLD
    } state_e;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_e;

    state_e           state_q, state_d;
    port_e            hold_port_q, hold_port_d;
    port_e            rr_prio_q;
    port_e            fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic  sel_valid;
    port_e sel_port;
    logic  push, pop;
    port_e head_port;
    logic  full;

    assign full      = (count_q == CNT_MAX);
    assign head_port = fifo_q[rd_ptr_q];

    // Port selection, next state and memory request channel mux.
    always_comb begin
        sel_valid   = 1'b0;
        sel_port    = PORT_A;
        state_d     = state_q;
        hold_port_d = hold_port_q;

        case (state_q)
            ARB: begin
                if (!full && (a_req_i || b_req_i)) begin
                    sel_valid = 1'b1;
                    if (a_req_i && !b_req_i) begin
                        sel_port = PORT_A;
                    end else if (!a_req_i && b_req_i) begin
                        sel_port = PORT_B;
                    end else begin
                        sel_port = rr_prio_q;
                    end
                    if (!m_gnt_i) begin
                        hold_port_d = sel_port;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                sel_valid = 1'b1;
                sel_port  = hold_port_q;
                if (m_gnt_i) begin
                    state_d = ARB;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase

        // Outputs are forced quiet while reset is held, even with requests active.
        if (!rst_ni) begin
            sel_valid = 1'b0;
        end

        m_req_o = sel_valid;
        if (sel_port == PORT_B) begin
            m_addr_o  = b_addr_i;
            m_we_o    = b_we_i;
            m_be_o    = b_be_i;
            m_wdata_o = b_wdata_i;
        end else begin
            m_addr_o  = a_addr_i;
            m_we_o    = a_we_i;
            m_be_o    = a_be_i;
            m_wdata_o = a_wdata_i;
        end

        push    = sel_valid && m_gnt_i;
        a_gnt_o = push && (sel_port == PORT_A);
        b_gnt_o = push && (sel_port == PORT_B);
    end

    // Response routing to the port at the head of the order FIFO.
    always_comb begin
        pop        = rst_ni && m_rvalid_i && (count_q != '0);
        a_rvalid_o = pop && (head_port == PORT_A);
        b_rvalid_o = pop && (head_port == PORT_B);
        a_rdata_o  = m_rdata_i;
        b_rdata_o  = m_rdata_i;
        a_err_o    = m_err_i;
        b_err_o    = m_err_i;
    end

    // Arbitration state, round-robin priority and held selection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB;
            hold_port_q <= PORT_A;
            rr_prio_q   <= PORT_A;
        end else begin
            state_q     <= state_d;
            hold_port_q <= hold_port_d;
            if (push) begin
                rr_prio_q <= (sel_port == PORT_A) ? PORT_B : PORT_A;
            end
        end
    end

    // Order FIFO of issued port ids; push and pop may coincide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= PORT_A;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sel_port;
                wr_ptr_q         <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky flag for a memory response with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            unexpected_rsp_o <= 1'b0;
        end else if (m_rvalid_i && (count_q == '0)) begin
            unexpected_rsp_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uvmt_cv32e40s_obi_mem_arbiter.sv
// Directed bench for the OBI memory arbiter: reset, single access, round
// robin, hold stability, full FIFO back-pressure, unexpected responses and
// reset in the middle of traffic.
module tb_uvmt_cv32e40s_obi_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          a_req_i, b_req_i, a_we_i, b_we_i;
    logic          a_gnt_o, b_gnt_o;
    logic [AW-1:0] a_addr_i, b_addr_i;
    logic [DW/8-1:0] a_be_i, b_be_i;
    logic [DW-1:0] a_wdata_i, b_wdata_i;
    logic          a_rvalid_o, b_rvalid_o, a_err_o, b_err_o;
    logic [DW-1:0] a_rdata_o, b_rdata_o;
    logic          m_req_o, m_we_o, m_gnt_i, m_rvalid_i, m_err_i;
    logic [AW-1:0] m_addr_o;
    logic [DW/8-1:0] m_be_o;
    logic [DW-1:0] m_wdata_o, m_rdata_i;
    logic          unexpected_rsp_o;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    uvmt_cv32e40s_obi_mem_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .a_req_i          (a_req_i),
        .a_gnt_o          (a_gnt_o),
        .a_addr_i         (a_addr_i),
        .a_we_i           (a_we_i),
        .a_be_i           (a_be_i),
        .a_wdata_i        (a_wdata_i),
        .a_rvalid_o       (a_rvalid_o),
        .a_rdata_o        (a_rdata_o),
        .a_err_o          (a_err_o),
        .b_req_i          (b_req_i),
        .b_gnt_o          (b_gnt_o),
        .b_addr_i         (b_addr_i),
        .b_we_i           (b_we_i),
        .b_be_i           (b_be_i),
        .b_wdata_i        (b_wdata_i),
        .b_rvalid_o       (b_rvalid_o),
        .b_rdata_o        (b_rdata_o),
        .b_err_o          (b_err_o),
        .m_req_o          (m_req_o),
        .m_addr_o         (m_addr_o),
        .m_we_o           (m_we_o),
        .m_be_o           (m_be_o),
        .m_wdata_o        (m_wdata_o),
        .m_gnt_i          (m_gnt_i),
        .m_rvalid_i       (m_rvalid_i),
        .m_rdata_i        (m_rdata_i),
        .m_err_i          (m_err_i),
        .unexpected_rsp_o (unexpected_rsp_o)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        a_req_i = 0; b_req_i = 0; a_we_i = 0; b_we_i = 0;
        a_addr_i = '0; b_addr_i = '0; a_be_i = '0; b_be_i = '0;
        a_wdata_i = '0; b_wdata_i = '0;
        m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = '0; m_err_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 0;
        step();
        step();
        rst_ni = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 0;
        a_req_i = 1; b_req_i = 1; m_gnt_i = 1; m_rvalid_i = 1;
        #2;
        vectors++;
        if ({a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, m_req_o, unexpected_rsp_o} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got gnt=%b%b rv=%b%b mreq=%b unexp=%b want all 0",
                     a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, m_req_o, unexpected_rsp_o);
        end
        do_reset();
    endtask

    task automatic test_single_a();
        do_reset();
        step();
        a_req_i = 1; a_addr_i = 32'h100; m_gnt_i = 1;
        #2;
        vectors++;
        if ({a_gnt_o, b_gnt_o, m_req_o} !== 3'b101 || m_addr_o !== 32'h100) begin
            miscompares++;
            $display("FAIL single_grant got gnt=%b%b mreq=%b addr=%h want 10 1 00000100",
                     a_gnt_o, b_gnt_o, m_req_o, m_addr_o);
        end
        step();
        a_req_i = 0; m_gnt_i = 0;
        step();
        m_rvalid_i = 1; m_rdata_i = 32'hDEADBEEF;
        #2;
        vectors++;
        if ({a_rvalid_o, b_rvalid_o} !== 2'b10 || a_rdata_o !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_rsp got rv=%b%b rdata=%h want 10 deadbeef",
                     a_rvalid_o, b_rvalid_o, a_rdata_o);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt [5];
        logic [1:0] exp_rv  [5];
        exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01; exp_gnt[4] = 2'b00;
        exp_rv[0]  = 2'b00; exp_rv[1]  = 2'b10; exp_rv[2]  = 2'b01; exp_rv[3]  = 2'b10; exp_rv[4]  = 2'b01;
        do_reset();
        step();
        for (int c = 0; c < 5; c++) begin
            a_req_i = (c < 4); b_req_i = (c < 4); m_gnt_i = (c < 4); m_rvalid_i = (c > 0);
            a_addr_i = 32'h10 + c; b_addr_i = 32'h20 + c;
            #2;
            vectors++;
            if ({a_gnt_o, b_gnt_o} !== exp_gnt[c] || {a_rvalid_o, b_rvalid_o} !== exp_rv[c]) begin
                miscompares++;
                $display("FAIL round_robin_c%0d got gnt=%b%b rv=%b%b want gnt=%b rv=%b",
                         c, a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, exp_gnt[c], exp_rv[c]);
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_hold();
        do_reset();
        step();
        a_req_i = 1; a_addr_i = 32'hA0; a_we_i = 1; a_be_i = 4'h3; a_wdata_i = 32'h12345678;
        b_addr_i = 32'hB0; b_we_i = 0; b_be_i = 4'hF; b_wdata_i = 32'h0;
        for (int c = 0; c < 4; c++) begin
            b_req_i = (c >= 1);
            m_gnt_i = (c == 3);
            #2;
            vectors++;
            if ({m_req_o, m_we_o, a_gnt_o, b_gnt_o} !== {3'b11, (c == 3), 1'b0} ||
                m_addr_o !== 32'hA0 || m_be_o !== 4'h3 || m_wdata_o !== 32'h12345678) begin
                miscompares++;
                $display("FAIL hold_c%0d got req=%b we=%b gnt=%b%b addr=%h be=%h wd=%h want 1 1 %b0 a0 3 12345678",
                         c, m_req_o, m_we_o, a_gnt_o, b_gnt_o, m_addr_o, m_be_o, m_wdata_o, (c == 3));
            end
            step();
        end
        a_req_i = 0;
        #2;
        vectors++;
        if ({a_gnt_o, b_gnt_o} !== 2'b01 || m_addr_o !== 32'hB0 || m_we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_then_b got gnt=%b%b addr=%h we=%b want 01 b0 0",
                     a_gnt_o, b_gnt_o, m_addr_o, m_we_o);
        end
        step();
        b_req_i = 0; m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h1111; m_err_i = 0;
        #2;
        vectors++;
        if ({a_rvalid_o, b_rvalid_o, a_err_o} !== 3'b100 || a_rdata_o !== 32'h1111) begin
            miscompares++;
            $display("FAIL hold_rsp_a got rv=%b%b err=%b rdata=%h want 10 0 1111",
                     a_rvalid_o, b_rvalid_o, a_err_o, a_rdata_o);
        end
        step();
        m_rdata_i = 32'h2222; m_err_i = 1;
        #2;
        vectors++;
        if ({a_rvalid_o, b_rvalid_o, b_err_o} !== 3'b011 || b_rdata_o !== 32'h2222) begin
            miscompares++;
            $display("FAIL hold_rsp_b got rv=%b%b err=%b rdata=%h want 01 1 2222",
                     a_rvalid_o, b_rvalid_o, b_err_o, b_rdata_o);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_full();
        // Per cycle: a_req b_req m_gnt m_rvalid | expected m_req a_gnt b_gnt a_rv b_rv
        logic [3:0] stim [7];
        logic [4:0] expv [7];
        stim[0] = 4'b1010; expv[0] = 5'b11000;
        stim[1] = 4'b0110; expv[1] = 5'b10100;
        stim[2] = 4'b1010; expv[2] = 5'b00000;
        stim[3] = 4'b1011; expv[3] = 5'b00010;
        stim[4] = 4'b1010; expv[4] = 5'b11000;
        stim[5] = 4'b0001; expv[5] = 5'b00001;
        stim[6] = 4'b0001; expv[6] = 5'b00010;
        do_reset();
        step();
        for (int c = 0; c < 7; c++) begin
            {a_req_i, b_req_i, m_gnt_i, m_rvalid_i} = stim[c];
            #2;
            vectors++;
            if ({m_req_o, a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o} !== expv[c]) begin
                miscompares++;
                $display("FAIL full_c%0d got req/gnt/rv=%b want %b", c,
                         {m_req_o, a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o}, expv[c]);
            end
            step();
        end
        clear_inputs();
        m_rvalid_i = 1;
        #2;
        vectors++;
        if ({a_rvalid_o, b_rvalid_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL full_drained got rv=%b%b want 00", a_rvalid_o, b_rvalid_o);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_unexpected();
        do_reset();
        step();
        m_rvalid_i = 1; m_rdata_i = 32'hCAFE;
        #2;
        vectors++;
        if ({a_rvalid_o, b_rvalid_o, unexpected_rsp_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL unexp_pulse got rv=%b%b unexp=%b want 000", a_rvalid_o, b_rvalid_o, unexpected_rsp_o);
        end
        step();
        m_rvalid_i = 0;
        step();
        step();
        #2;
        vectors++;
        if (unexpected_rsp_o !== 1'b1) begin
            miscompares++;
            $display("FAIL unexp_sticky got %b want 1", unexpected_rsp_o);
        end
        rst_ni = 0;
        #1;
        vectors++;
        if (unexpected_rsp_o !== 1'b0) begin
            miscompares++;
            $display("FAIL unexp_cleared got %b want 0", unexpected_rsp_o);
        end
        step();
        rst_ni = 1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        step();
        a_req_i = 1; m_gnt_i = 1;
        step();
        a_req_i = 0; b_req_i = 1; m_gnt_i = 0;
        step();
        a_req_i = 1; b_req_i = 1; m_gnt_i = 1; m_rvalid_i = 1; rst_ni = 0;
        #2;
        vectors++;
        if ({a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, m_req_o} !== 5'b0) begin
            miscompares++;
            $display("FAIL mid_reset got gnt=%b%b rv=%b%b mreq=%b want all 0",
                     a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, m_req_o);
        end
        step();
        rst_ni = 1; a_req_i = 0; b_req_i = 0; m_gnt_i = 0; m_rvalid_i = 1;
        #2;
        vectors++;
        if ({a_rvalid_o, b_rvalid_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL late_rsp_routed got rv=%b%b want 00", a_rvalid_o, b_rvalid_o);
        end
        step();
        m_rvalid_i = 0;
        #2;
        vectors++;
        if (unexpected_rsp_o !== 1'b1) begin
            miscompares++;
            $display("FAIL late_rsp_flag got %b want 1", unexpected_rsp_o);
        end
        a_req_i = 1; b_req_i = 1; m_gnt_i = 1;
        #1;
        vectors++;
        if ({a_gnt_o, b_gnt_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL prio_after_reset got gnt=%b%b want 10", a_gnt_o, b_gnt_o);
        end
        step();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_ni = 1;
        #3;
        test_reset();
        test_single_a();
        test_round_robin();
        test_hold();
        test_full();
        test_unexpected();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
